// File: rtl/tas_pkg.sv
// rtl/tas_pkg.sv - shared types and constants for the temperature averaging controller
package tas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SKIP,
        WRITE
    } tas_state_e;

    localparam logic [7:0] HDR_AVG_DEF  = 8'hA5;
    localparam logic [7:0] HDR_SKIP_DEF = 8'hC3;
    localparam int         SAMPLES_DEF  = 4;

    function automatic int tas_log2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/tas_accum.sv
// rtl/tas_accum.sv - sample accumulator, counter and divide; TAS_AVG_ROUND_EN selects round-half-up
module tas_accum
    import tas_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SAMPLES = SAMPLES_DEF
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic              last,
    output logic [DATA_W-1:0] avg
);

    localparam int LW = tas_log2(SAMPLES);
    localparam int AW = DATA_W + LW;

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [AW-1:0] sum_r;
    logic [LW-1:0] cnt;

    // avg reflects the byte being presented, so the FSM can latch it on the last sample
    assign sum = acc + AW'(din);

`ifdef TAS_AVG_ROUND_EN
    assign sum_r = sum + AW'(SAMPLES / 2);
`else
    assign sum_r = sum;
`endif

    assign avg  = sum_r[AW-1:LW];
    assign last = (cnt == LW'(SAMPLES - 1));

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tas_avg_ctrl.sv
// rtl/tas_avg_ctrl.sv - packet parser and RAM write strobe generator; TAS_AVG_ROUND_EN enables rounding
module tas_avg_ctrl
    import tas_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SAMPLES  = SAMPLES_DEF,
    parameter logic [DATA_W-1:0] HDR_AVG  = HDR_AVG_DEF,
    parameter logic [DATA_W-1:0] HDR_SKIP = HDR_SKIP_DEF
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_ena,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wr_n,
    output logic              busy,
    output logic              hdr_err
);

    tas_state_e        state;
    logic              hdr_phase;
    logic              is_avg;
    logic              is_skip;
    logic              acc_clr;
    logic              acc_add;
    logic              acc_last;
    logic [DATA_W-1:0] acc_avg;

    // WRITE decodes headers exactly like IDLE so back-to-back packets lose no bytes
    assign hdr_phase = (state == IDLE) || (state == WRITE);
    assign is_avg    = (data_in == HDR_AVG);
    assign is_skip   = (data_in == HDR_SKIP);
    assign acc_clr   = data_ena && hdr_phase && (is_avg || is_skip);
    assign acc_add   = data_ena && ((state == COLLECT) || (state == SKIP));
    assign busy      = (state != IDLE);

    tas_accum #(
        .DATA_W  (DATA_W),
        .SAMPLES (SAMPLES)
    ) u_accum (
        .clk_2 (clk_2),
        .reset (reset),
        .clr   (acc_clr),
        .add   (acc_add),
        .din   (data_in),
        .last  (acc_last),
        .avg   (acc_avg)
    );

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ram_data <= '0;
            ram_wr_n <= 1'b1;
            hdr_err  <= 1'b0;
        end else begin
            ram_wr_n <= 1'b1;
            hdr_err  <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    state <= IDLE;
                    if (data_ena) begin
                        if (is_avg) begin
                            state <= COLLECT;
                        end else if (is_skip) begin
                            state <= SKIP;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (data_ena && acc_last) begin
                        ram_data <= acc_avg;
                        ram_wr_n <= 1'b0;
                        state    <= WRITE;
                    end
                end
                SKIP: begin
                    if (data_ena && acc_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tas_avg_ctrl.sv
// tb/tb_tas_avg_ctrl.sv - self-checking bench for tas_avg_ctrl
module tb_tas_avg_ctrl;

`ifdef TAS_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic       clk_2    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       data_ena = 1'b0;
    logic [7:0] ram_data;
    logic       ram_wr_n;
    logic       busy;
    logic       hdr_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_data;
    logic       prev_low = 1'b0;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] data;
        int          gap;
        bit          strobe;
        logic [7:0]  exp_t;
        logic [7:0]  exp_r;
    } vec_t;

    vec_t vecs[6];

    tas_avg_ctrl dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .data_in  (data_in),
        .data_ena (data_ena),
        .ram_data (ram_data),
        .ram_wr_n (ram_wr_n),
        .busy     (busy),
        .hdr_err  (hdr_err)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every strobe must match the oldest pending expectation
    always @(negedge clk_2) begin
        if (!reset) begin
            if (ram_wr_n === 1'b0) begin
                check("no_double_strobe", int'(prev_low), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got ram_data 0x%0h with nothing pending", ram_data);
                end else begin
                    check("strobe_data", int'(ram_data), int'(exp_q.pop_front()));
                end
            end
            prev_low = (ram_wr_n === 1'b0);
        end else begin
            prev_low = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        data_ena = 1'b0;
        repeat (gap) @(negedge clk_2);
        data_in  = b;
        data_ena = 1'b1;
        @(negedge clk_2);
        data_ena = 1'b0;
    endtask

    task automatic idle(input int n);
        data_ena = 1'b0;
        repeat (n) @(negedge clk_2);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] d, input int gap,
                            input bit strobe, input logic [7:0] exp_val);
        send_byte(hdr, gap);
        check("busy_after_hdr", int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && strobe) exp_q.push_back(exp_val);
            send_byte(d[i*8 +: 8], gap);
            if (i < 3) begin
                check("busy_in_pkt", int'(busy), 1);
            end else if (strobe) begin
                check("strobe_latency", int'(ram_wr_n), 0);
                check("busy_in_write", int'(busy), 1);
                last_data = exp_val;
            end else begin
                check("skip_no_strobe", int'(ram_wr_n), 1);
                check("skip_busy_low", int'(busy), 0);
                check("skip_data_held", int'(ram_data), int'(last_data));
            end
        end
    endtask

    initial begin
        int c1;
        int c2;

        vecs[0] = '{8'hA5, 32'h2A1E140A, 0, 1'b1, 8'h19, 8'h1A};
        vecs[1] = '{8'hA5, 32'hFFFFFFFF, 0, 1'b1, 8'hFF, 8'hFF};
        vecs[2] = '{8'hC3, 32'h44332211, 0, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'hA5, 32'h04040404, 0, 1'b1, 8'h04, 8'h04};
        vecs[4] = '{8'hA5, 32'h00010101, 3, 1'b1, 8'h00, 8'h01};
        vecs[5] = '{8'hA5, 32'h0B090807, 2, 1'b1, 8'h08, 8'h09};
        last_data = 8'h00;

        repeat (2) @(negedge clk_2);
        check("rst_wr_n", int'(ram_wr_n), 1);
        check("rst_data", int'(ram_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_hdr_err", int'(hdr_err), 0);
        reset = 1'b0;
        idle(1);

        foreach (vecs[i]) begin
            send_pkt(vecs[i].hdr, vecs[i].data, vecs[i].gap, vecs[i].strobe,
                     ROUND ? vecs[i].exp_r : vecs[i].exp_t);
            idle(1);
            check("wr_n_released", int'(ram_wr_n), 1);
        end

        // unrecognised header in IDLE
        send_byte(8'h00, 0);
        check("hdr_err_pulse", int'(hdr_err), 1);
        check("hdr_err_stay_idle", int'(busy), 0);
        idle(1);
        check("hdr_err_one_cycle", int'(hdr_err), 0);
        send_pkt(8'hA5, 32'h0D0C0B0A, 0, 1'b1, ROUND ? 8'h0C : 8'h0B);
        idle(2);

        // reset in the middle of a packet
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h10, 0);
        check("partial_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_wr_n", int'(ram_wr_n), 1);
        check("async_rst_data", int'(ram_data), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_hdr_err", int'(hdr_err), 0);
        @(negedge clk_2);
        check("held_rst_busy", int'(busy), 0);
        reset = 1'b0;
        last_data = 8'h00;
        idle(1);
        send_pkt(8'hA5, 32'h08080808, 0, 1'b1, 8'h08);
        idle(2);

        // back-to-back: second header lands in the WRITE cycle
        send_pkt(8'hA5, 32'h01010101, 0, 1'b1, 8'h01);
        c1 = cyc;
        send_pkt(8'hA5, 32'h02020202, 0, 1'b1, 8'h02);
        c2 = cyc;
        check("b2b_spacing", c2 - c1, 5);
        idle(3);
        check("data_holds", int'(ram_data), int'(last_data));
        check("all_strobes_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
